// File: rtl/qos_tx_ctrl_pkg.sv
// Shared widths, FSM encoding and slot payload for the qos transmit controller.
package qos_tx_ctrl_pkg;

    localparam int unsigned DATA_WIDTH     = 4;
    localparam int unsigned QUEUE_QUANTITY = 4;
    localparam int unsigned VC_WIDTH       = 2;
    localparam int unsigned CNT_WIDTH      = 8;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        ACTIVE    = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    typedef struct packed {
        logic                  full;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

endpackage

// File: rtl/qos_tx_ctrl_rr.sv
// Four-way round-robin arbiter: first eligible VC at or after the pointer, modulo 4.
module qos_tx_ctrl_rr
    import qos_tx_ctrl_pkg::*;
(
    input  logic [QUEUE_QUANTITY-1:0] eligible,
    input  logic [VC_WIDTH-1:0]       ptr,
    output logic [VC_WIDTH-1:0]       grant,
    output logic                      valid
);

    logic [VC_WIDTH-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            idx = ptr + VC_WIDTH'(i);
            if (!valid && eligible[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/qos_tx_ctrl.sv
// Transmit controller: one holding slot per VC, pause/overflow tracking and
// round-robin emission of one word per cycle towards the qos block.
module qos_tx_ctrl
    import qos_tx_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic                      init,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [VC_WIDTH-1:0]       req_vc,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [QUEUE_QUANTITY-1:0] pausa_qos,
    input  logic [QUEUE_QUANTITY-1:0] continue_qos,
    input  logic [QUEUE_QUANTITY-1:0] error_full_qos,
    input  logic                      idle_qos,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [VC_WIDTH-1:0]       vc_id_out,
    output logic                      wr_out,
    output logic [QUEUE_QUANTITY-1:0] paused,
    output logic [QUEUE_QUANTITY-1:0] err_sticky,
    output logic [CNT_WIDTH-1:0]      sent_count,
    output logic                      idle_tx
);

    state_t                    state;
    state_t                    state_next;
    logic                      run;
    logic                      clear;
    slot_t                     slots [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic                      any_full;
    logic [VC_WIDTH-1:0]       rr_ptr;
    logic [VC_WIDTH-1:0]       gnt;
    logic                      gnt_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_INIT;
        else     state <= state_next;
    end

    // init takes priority over arbitration; FLUSH spends one enabled cycle clearing.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        clear      = 1'b0;
        case (state)
            WAIT_INIT: if (enb && init) state_next = ACTIVE;
            ACTIVE: begin
                if (enb) begin
                    if (init) state_next = FLUSH;
                    else      run = 1'b1;
                end
            end
            FLUSH: begin
                if (enb) begin
                    clear      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            default: state_next = WAIT_INIT;
        endcase
    end

    always_comb begin
        eligible = '0;
        any_full = 1'b0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = slots[i].full && !paused[i];
            any_full    = any_full | slots[i].full;
        end
    end

    assign req_ready = enb && (state == ACTIVE) && !slots[req_vc].full;
    assign idle_tx   = !any_full && !wr_out && idle_qos;

    qos_tx_ctrl_rr u_rr (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (gnt),
        .valid    (gnt_valid)
    );

    // Granted and refilled slots are disjoint: a full slot never shows req_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) slots[i] <= '0;
            paused     <= '0;
            err_sticky <= '0;
            rr_ptr     <= '0;
            data_out   <= '0;
            vc_id_out  <= '0;
            wr_out     <= 1'b0;
            sent_count <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) slots[i] <= '0;
            paused     <= '0;
            err_sticky <= '0;
            rr_ptr     <= '0;
            wr_out     <= 1'b0;
            sent_count <= '0;
        end else if (run) begin
            paused     <= pausa_qos | (paused & ~continue_qos);
            err_sticky <= err_sticky | error_full_qos;
            wr_out     <= gnt_valid;
            if (gnt_valid) begin
                slots[gnt].full <= 1'b0;
                data_out        <= slots[gnt].data;
                vc_id_out       <= gnt;
                rr_ptr          <= gnt + VC_WIDTH'(1);
                sent_count      <= sent_count + CNT_WIDTH'(1);
            end
            if (req_valid && req_ready) begin
                slots[req_vc] <= '{full: 1'b1, data: req_data};
            end
        end else begin
            wr_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qos_tx_ctrl.sv
// Scoreboard bench for qos_tx_ctrl: expected words queued at submission, checked on wr_out.
module tb_qos_tx_ctrl;

    typedef struct packed {
        logic [1:0] vc;
        logic [3:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       init;
    logic [3:0] req_data;
    logic [1:0] req_vc;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] pausa_qos;
    logic [3:0] continue_qos;
    logic [3:0] error_full_qos;
    logic       idle_qos;
    logic [3:0] data_out;
    logic [1:0] vc_id_out;
    logic       wr_out;
    logic [3:0] paused;
    logic [3:0] err_sticky;
    logic [7:0] sent_count;
    logic       idle_tx;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    qos_tx_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enb            (enb),
        .init           (init),
        .req_data       (req_data),
        .req_vc         (req_vc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .pausa_qos      (pausa_qos),
        .continue_qos   (continue_qos),
        .error_full_qos (error_full_qos),
        .idle_qos       (idle_qos),
        .data_out       (data_out),
        .vc_id_out      (vc_id_out),
        .wr_out         (wr_out),
        .paused         (paused),
        .err_sticky     (err_sticky),
        .sent_count     (sent_count),
        .idle_tx        (idle_tx)
    );

    // Scoreboard: every emitted word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got vc=%0d data=%h, required no write", vc_id_out, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({vc_id_out, data_out} !== e) begin
                    bad++;
                    $display("FAIL sb_word: got vc=%0d data=%h, required vc=%0d data=%h",
                             vc_id_out, data_out, e.vc, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        step();
        init = 1'b0;
        step();
    endtask

    task automatic send(input logic [1:0] vc, input logic [3:0] d, input bit expect_out);
        int n;
        n         = 0;
        req_vc    = vc;
        req_data  = d;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: req_ready=%b for vc=%0d, required 1", req_ready, vc);
        end else if (expect_out) begin
            exp_q.push_back({vc, d});
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b1; init = 1'b0; req_data = '0; req_vc = '0; req_valid = 1'b0;
        pausa_qos = '0; continue_qos = '0; error_full_qos = '0; idle_qos = 1'b1;
        #2;
        total++; if (wr_out !== 1'b0)     begin bad++; $display("FAIL rst_wr: got %b required 0", wr_out); end
        total++; if (data_out !== 4'h0)   begin bad++; $display("FAIL rst_data: got %h required 0", data_out); end
        total++; if (vc_id_out !== 2'd0)  begin bad++; $display("FAIL rst_vc: got %0d required 0", vc_id_out); end
        total++; if (sent_count !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d required 0", sent_count); end
        total++; if (paused !== 4'h0)     begin bad++; $display("FAIL rst_paused: got %b required 0000", paused); end
        total++; if (err_sticky !== 4'h0) begin bad++; $display("FAIL rst_err: got %b required 0000", err_sticky); end
        total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        total++; if (idle_tx !== 1'b1)    begin bad++; $display("FAIL rst_idle: got %b required 1", idle_tx); end
        step();
        rst = 1'b0;
        step();
        total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL wait_init_ready: got %b required 0", req_ready); end
    endtask

    task automatic test_basic();
        pulse_init();
        send(2'd0, 4'h3, 1'b1);
        send(2'd2, 4'h5, 1'b1);
        repeat (4) step();
        total++; if (sent_count !== 8'd2) begin bad++; $display("FAIL basic_cnt: got %0d required 2", sent_count); end
        total++; if (exp_q.size() != 0)   begin bad++; $display("FAIL basic_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        pulse_init();
        pulse_init();
        pausa_qos = 4'hF;
        step();
        pausa_qos = 4'h0;
        total++; if (paused !== 4'hF) begin bad++; $display("FAIL rr_paused: got %b required 1111", paused); end
        for (int i = 0; i < 4; i++) send(2'(i), 4'(10 + i), 1'b1);
        continue_qos = 4'hF;
        step();
        continue_qos = 4'h0;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_out !== 1'b1 || vc_id_out !== 2'(i)) begin
                bad++;
                $display("FAIL rr_seq%0d: got wr=%b vc=%0d required wr=1 vc=%0d", i, wr_out, vc_id_out, i);
            end
            step();
        end
    endtask

    task automatic test_pause();
        pausa_qos = 4'b0010;
        step();
        pausa_qos = 4'h0;
        send(2'd1, 4'h7, 1'b1);
        repeat (3) begin
            total++;
            if (wr_out !== 1'b0 || paused !== 4'b0010) begin
                bad++;
                $display("FAIL pause_hold: got wr=%b paused=%b required wr=0 paused=0010", wr_out, paused);
            end
            step();
        end
        continue_qos = 4'b0010;
        step();
        continue_qos = 4'h0;
        step();
        total++;
        if (wr_out !== 1'b1 || vc_id_out !== 2'd1 || paused !== 4'h0) begin
            bad++;
            $display("FAIL pause_resume: got wr=%b vc=%0d paused=%b required wr=1 vc=1 paused=0000",
                     wr_out, vc_id_out, paused);
        end
        pausa_qos = 4'b1000;
        continue_qos = 4'b1000;
        req_vc = 2'd3;
        step();
        pausa_qos = 4'h0;
        continue_qos = 4'h0;
        total++; if (paused !== 4'b1000) begin bad++; $display("FAIL pause_both: got %b required 1000", paused); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL pause_ready3: got %b required 1", req_ready); end
        continue_qos = 4'b1000;
        step();
        continue_qos = 4'h0;
        total++; if (paused !== 4'h0) begin bad++; $display("FAIL pause_clear3: got %b required 0000", paused); end
    endtask

    task automatic test_error();
        error_full_qos = 4'b0100;
        step();
        error_full_qos = 4'h0;
        repeat (3) step();
        total++; if (err_sticky !== 4'b0100) begin bad++; $display("FAIL err_sticky: got %b required 0100", err_sticky); end
        pausa_qos = 4'b0001;
        step();
        pausa_qos = 4'h0;
        send(2'd0, 4'h9, 1'b0);
        total++; if (idle_tx !== 1'b0) begin bad++; $display("FAIL err_busy: got idle=%b required 0", idle_tx); end
        pulse_init();
        step();
        total++; if (err_sticky !== 4'h0) begin bad++; $display("FAIL err_clear: got %b required 0000", err_sticky); end
        total++; if (paused !== 4'h0)     begin bad++; $display("FAIL err_paused: got %b required 0000", paused); end
        total++; if (idle_tx !== 1'b1)    begin bad++; $display("FAIL err_slots: got idle=%b required 1", idle_tx); end
        total++; if (sent_count !== 8'd0) begin bad++; $display("FAIL err_cnt: got %0d required 0", sent_count); end
        repeat (3) step();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 256; k++) begin
            send(2'(k), 4'(k * 7), 1'b1);
            if (k == 127) begin
                step();
                total++;
                if (sent_count !== 8'd128) begin bad++; $display("FAIL wrap_mid: got %0d required 128", sent_count); end
            end
        end
        repeat (3) step();
        total++; if (sent_count !== 8'd0) begin bad++; $display("FAIL wrap_cnt: got %0d required 0", sent_count); end
        total++; if (exp_q.size() != 0)   begin bad++; $display("FAIL wrap_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_rst_mid();
        pausa_qos = 4'hF;
        step();
        pausa_qos = 4'h0;
        for (int i = 0; i < 4; i++) send(2'(i), 4'(i + 5), 1'b1);
        continue_qos = 4'hF;
        step();
        continue_qos = 4'h0;
        step();
        rst = 1'b1;
        #1;
        total++;
        if (wr_out !== 1'b0 || data_out !== 4'h0 || vc_id_out !== 2'd0) begin
            bad++;
            $display("FAIL arst_out: got wr=%b data=%h vc=%0d required all 0", wr_out, data_out, vc_id_out);
        end
        total++;
        if (sent_count !== 8'd0 || paused !== 4'h0 || err_sticky !== 4'h0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL arst_state: got cnt=%0d paused=%b err=%b ready=%b required all 0",
                     sent_count, paused, err_sticky, req_ready);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
        pulse_init();
        repeat (4) step();
        total++;
        if (idle_tx !== 1'b1 || sent_count !== 8'd0) begin
            bad++;
            $display("FAIL arst_discard: got idle=%b cnt=%0d required idle=1 cnt=0", idle_tx, sent_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_pause();
        test_error();
        test_wrap();
        test_rst_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_drain: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
